// File: rtl/sync_nd_filt_pkg.sv
// Shared definitions for the N-stage filtered synchronizer bank: legal parameter
// ranges, counter-width helper and the per-channel output bundle.
package sync_nd_filt_pkg;

  localparam int unsigned DEPTH_MIN = 2;
  localparam int unsigned DEPTH_MAX = 6;
  localparam int unsigned FILT_MIN  = 1;
  localparam int unsigned FILT_MAX  = 255;

  typedef struct packed {
    logic q;
    logic rise;
    logic fall;
  } chan_out_t;

  function automatic bit depth_legal(input int unsigned depth);
    return (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX);
  endfunction

  function automatic bit filt_legal(input int unsigned filt);
    return (filt >= FILT_MIN) && (filt <= FILT_MAX);
  endfunction

  // Never returns zero so a FILT=1 counter still has a legal 1-bit vector.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/sync_nd_filt_if.sv
// Level/pulse bundle between the asynchronous source side and the synchronized
// consumer side of a sync_nd_filt bank.
interface sync_nd_filt_if #(
  parameter int unsigned WIDTH = 1
);

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             chg;

  modport master (
    output d,
    input  q,
    input  rise,
    input  fall,
    input  chg
  );

  modport slave (
    input  d,
    output q,
    output rise,
    output fall,
    output chg
  );

endinterface

// File: rtl/sync_nd_filt_chan.sv
// Single-bit channel: DEPTH-stage synchronizer chain, stability filter, output
// level flop and registered rise/fall pulses.
module sync_nd_filt_chan
  import sync_nd_filt_pkg::*;
#(
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned FILT    = 1,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic      clk,
  input  logic      rst_,
  input  logic      d_i,
  output chan_out_t out_o
);

  localparam int unsigned    CntW    = clog2_min1(FILT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(FILT - 1);

  (* preserve, dont_touch = "true" *) logic [DEPTH-1:0] stage_q;

  logic            sl;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            q_q, q_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  assign sl = stage_q[DEPTH-1];

  always_ff @(posedge clk) begin
    if (!rst_) begin
      stage_q <= {DEPTH{RST_VAL}};
      cnt_q   <= '0;
      q_q     <= RST_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      stage_q <= {stage_q[DEPTH-2:0], d_i};
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Any cycle where sl agrees with q discards the running count, so a
  // glitch shorter than FILT cycles never reaches q.
  always_comb begin
    cnt_d  = '0;
    q_d    = q_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sl != q_q) begin
      if (cnt_q == CntLast) begin
        q_d    = sl;
        rise_d = sl;
        fall_d = ~sl;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign out_o = '{q: q_q, rise: rise_q, fall: fall_q};

endmodule

// File: rtl/sync_nd_filt.sv
// Bank of WIDTH independent filtered synchronizers with per-bit edge pulses and a
// bank-wide change flag.
module sync_nd_filt
  import sync_nd_filt_pkg::*;
#(
  parameter int unsigned     WIDTH   = 1,
  parameter int unsigned     DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter int unsigned     FILT    = 1
) (
  input logic           clk,
  input logic           rst_,
  sync_nd_filt_if.slave bus
);

  if (!depth_legal(DEPTH)) begin : g_depth_err
    $error("sync_nd_filt: DEPTH must be within 2..6");
  end

  if (!filt_legal(FILT)) begin : g_filt_err
    $error("sync_nd_filt: FILT must be within 1..255");
  end

  logic [WIDTH-1:0] q_w;
  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] fall_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    chan_out_t chan_out;

    sync_nd_filt_chan #(
      .DEPTH  (DEPTH),
      .FILT   (FILT),
      .RST_VAL(RST_VAL[i])
    ) u_chan (
      .clk  (clk),
      .rst_ (rst_),
      .d_i  (bus.d[i]),
      .out_o(chan_out)
    );

    assign q_w[i]    = chan_out.q;
    assign rise_w[i] = chan_out.rise;
    assign fall_w[i] = chan_out.fall;
  end

  assign bus.q    = q_w;
  assign bus.rise = rise_w;
  assign bus.fall = fall_w;
  // Built from registered pulses only, so it cannot glitch.
  assign bus.chg  = |(rise_w | fall_w);

endmodule

// File: tb/tb_sync_nd_filt.sv
// Directed bench for sync_nd_filt using three differently parameterised banks.
module tb_sync_nd_filt;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sync_nd_filt_if #(.WIDTH(4)) if_a ();
  sync_nd_filt_if #(.WIDTH(2)) if_b ();
  sync_nd_filt_if #(.WIDTH(8)) if_c ();

  // A: reset value, FILT=1 latency and toggling.
  sync_nd_filt #(.WIDTH(4), .DEPTH(3), .RST_VAL(4'b1010), .FILT(1)) dut_a (
    .clk (clk),
    .rst_(rst_a),
    .bus (if_a.slave)
  );

  // B: filtering and reset during a pending count.
  sync_nd_filt #(.WIDTH(2), .DEPTH(2), .RST_VAL(2'b00), .FILT(4)) dut_b (
    .clk (clk),
    .rst_(rst_b),
    .bus (if_b.slave)
  );

  // C: wide simultaneous transitions.
  sync_nd_filt #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'h00), .FILT(2)) dut_c (
    .clk (clk),
    .rst_(rst_c),
    .bus (if_c.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int t = 0; t < 3; t++) tick();
    total++;
    if (if_a.q !== 4'b1010) begin
      bad++; $display("FAIL reset_q got=%b exp=1010", if_a.q);
    end
    total++;
    if ({if_a.rise, if_a.fall, if_a.chg} !== 9'b0) begin
      bad++; $display("FAIL reset_pulses got=%b/%b/%b exp=0", if_a.rise, if_a.fall, if_a.chg);
    end
    rst_a = 1'b1;
    // First capture of d=0101 is tick 1; q follows at tick 1+DEPTH.
    for (int t = 1; t <= 5; t++) begin
      logic [3:0] eq, er, ef;
      tick();
      eq = (t >= 4) ? 4'b0101 : 4'b1010;
      er = (t == 4) ? 4'b0101 : 4'b0000;
      ef = (t == 4) ? 4'b1010 : 4'b0000;
      total++;
      if (if_a.q !== eq || if_a.rise !== er || if_a.fall !== ef || if_a.chg !== (t == 4)) begin
        bad++;
        $display("FAIL reset_release t=%0d got q=%b r=%b f=%b c=%b exp q=%b r=%b f=%b c=%b",
                 t, if_a.q, if_a.rise, if_a.fall, if_a.chg, eq, er, ef, (t == 4));
      end
    end
  endtask

  task automatic test_single_rise();
    if_a.d = 4'b0111;
    for (int t = 1; t <= 5; t++) begin
      logic [3:0] eq, er;
      tick();
      eq = (t >= 4) ? 4'b0111 : 4'b0101;
      er = (t == 4) ? 4'b0010 : 4'b0000;
      total++;
      if (if_a.q !== eq || if_a.rise !== er || if_a.fall !== 4'b0 || if_a.chg !== (t == 4)) begin
        bad++;
        $display("FAIL single_rise t=%0d got q=%b r=%b f=%b c=%b exp q=%b r=%b c=%b",
                 t, if_a.q, if_a.rise, if_a.fall, if_a.chg, eq, er, (t == 4));
      end
    end
  endtask

  task automatic test_toggle();
    logic hist [16];
    logic qe, qp;
    qp = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      if (t <= 10) if_a.d[0] = ~if_a.d[0];
      hist[t-1] = if_a.d[0];
      tick();
      qe = (t >= 4) ? hist[t-4] : 1'b1;
      total++;
      if (if_a.q !== {3'b011, qe} || if_a.rise[0] !== (qe & ~qp) ||
          if_a.fall[0] !== (~qe & qp)) begin
        bad++;
        $display("FAIL toggle t=%0d got q=%b r0=%b f0=%b exp q=011%b r0=%b f0=%b",
                 t, if_a.q, if_a.rise[0], if_a.fall[0], qe, qe & ~qp, ~qe & qp);
      end
      total++;
      if ((if_a.rise[0] & if_a.fall[0]) !== 1'b0) begin
        bad++; $display("FAIL toggle_overlap t=%0d got=1 exp=0", t);
      end
      qp = qe;
    end
  endtask

  task automatic test_glitch();
    rst_b = 1'b1;
    for (int t = 0; t < 4; t++) tick();
    total++;
    if (if_b.q !== 2'b00 || if_b.chg !== 1'b0) begin
      bad++; $display("FAIL glitch_idle got q=%b c=%b exp q=00 c=0", if_b.q, if_b.chg);
    end
    // Three-cycle excursion against FILT=4 must be swallowed.
    for (int t = 1; t <= 10; t++) begin
      if_b.d = (t <= 3) ? 2'b01 : 2'b00;
      tick();
      total++;
      if (if_b.q !== 2'b00 || if_b.rise !== 2'b00 || if_b.fall !== 2'b00) begin
        bad++;
        $display("FAIL glitch_reject t=%0d got q=%b r=%b f=%b exp 00/00/00",
                 t, if_b.q, if_b.rise, if_b.fall);
      end
    end
    if_b.d = 2'b01;
    for (int t = 1; t <= 7; t++) begin
      logic [1:0] eq, er;
      tick();
      eq = (t >= 6) ? 2'b01 : 2'b00;
      er = (t == 6) ? 2'b01 : 2'b00;
      total++;
      if (if_b.q !== eq || if_b.rise !== er || if_b.fall !== 2'b00 || if_b.chg !== (t == 6)) begin
        bad++;
        $display("FAIL filt_stable t=%0d got q=%b r=%b f=%b c=%b exp q=%b r=%b c=%b",
                 t, if_b.q, if_b.rise, if_b.fall, if_b.chg, eq, er, (t == 6));
      end
    end
  endtask

  task automatic test_reset_mid_count();
    if_b.d = 2'b11;
    // After four edges bit 1 has counted to FILT-2.
    for (int t = 1; t <= 4; t++) begin
      tick();
      total++;
      if (if_b.q !== 2'b01 || if_b.rise !== 2'b00) begin
        bad++; $display("FAIL mid_pre t=%0d got q=%b r=%b exp q=01 r=00", t, if_b.q, if_b.rise);
      end
    end
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    total++;
    if (if_b.q !== 2'b00 || if_b.rise !== 2'b00 || if_b.fall !== 2'b00 || if_b.chg !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got q=%b r=%b f=%b c=%b exp 00/00/00/0",
               if_b.q, if_b.rise, if_b.fall, if_b.chg);
    end
    for (int t = 1; t <= 7; t++) begin
      logic [1:0] eq, er;
      tick();
      eq = (t >= 6) ? 2'b11 : 2'b00;
      er = (t == 6) ? 2'b11 : 2'b00;
      total++;
      if (if_b.q !== eq || if_b.rise !== er || if_b.fall !== 2'b00) begin
        bad++;
        $display("FAIL mid_restart t=%0d got q=%b r=%b f=%b exp q=%b r=%b f=00",
                 t, if_b.q, if_b.rise, if_b.fall, eq, er);
      end
    end
  endtask

  task automatic test_back_to_back_wide();
    int chg_cnt;
    rst_c = 1'b1;
    for (int t = 0; t < 5; t++) tick();
    total++;
    if (if_c.q !== 8'h00) begin
      bad++; $display("FAIL wide_idle got=%h exp=00", if_c.q);
    end
    for (int pass = 0; pass < 2; pass++) begin
      logic [7:0] target;
      target  = (pass == 0) ? 8'hFF : 8'h00;
      if_c.d  = target;
      chg_cnt = 0;
      // DEPTH=3, FILT=2: first capture at tick 1, q updates at tick 5.
      for (int t = 1; t <= 7; t++) begin
        logic [7:0] eq, ep;
        tick();
        if (if_c.chg === 1'b1) chg_cnt++;
        eq = (t >= 5) ? target : ~target;
        ep = (t == 5) ? 8'hFF : 8'h00;
        total++;
        if (if_c.q !== eq || if_c.rise !== (pass == 0 ? ep : 8'h00) ||
            if_c.fall !== (pass == 1 ? ep : 8'h00)) begin
          bad++;
          $display("FAIL wide_edge p=%0d t=%0d got q=%h r=%h f=%h exp q=%h pulse=%h",
                   pass, t, if_c.q, if_c.rise, if_c.fall, eq, ep);
        end
      end
      total++;
      if (chg_cnt != 1) begin
        bad++; $display("FAIL wide_chg_count p=%0d got=%0d exp=1", pass, chg_cnt);
      end
    end
    if_c.d = 8'h08;
    tick();
    if_c.d = 8'h00;
    for (int t = 0; t < 8; t++) begin
      tick();
      total++;
      if (if_c.q !== 8'h00 || if_c.chg !== 1'b0) begin
        bad++; $display("FAIL wide_glitch t=%0d got q=%h c=%b exp q=00 c=0", t, if_c.q, if_c.chg);
      end
    end
  endtask

  initial begin
    rst_a  = 1'b0;
    rst_b  = 1'b0;
    rst_c  = 1'b0;
    if_a.d = 4'b0101;
    if_b.d = 2'b00;
    if_c.d = 8'h00;
    test_reset();
    test_single_rise();
    test_toggle();
    test_glitch();
    test_reset_mid_count();
    test_back_to_back_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
